param_timer_bank: RTL

Parametrised successor to the alarm system's fixed four-entry time-parameter store. It holds NUM_PARAMS reprogrammable interval values with reset defaults, and provides the same combinational readout. It also contains an integrated countdown timer with prescaler, start/cancel control and an expiry pulse. It sits between the alarm FSM, which selects and starts intervals, and the user programming inputs.

---
 rtl/param_timer_bank.sv | 136 +++++++++++++
 1 files changed

// File: rtl/param_timer_bank.sv
// Bank of NUM_PARAMS reprogrammable interval registers with a prescaled countdown timer.
// Optional build macro PARAM_TIMER_ZERO_REJECT_EN rejects writes of a zero interval.
module param_timer_bank #(
    parameter int unsigned NUM_PARAMS = 4,
    parameter int unsigned VALUE_W    = 4,
    parameter int unsigned SEL_W      = 2,
    parameter logic [NUM_PARAMS*VALUE_W-1:0] DEFAULTS = {4'd10, 4'd15, 4'd8, 4'd6},
    parameter int unsigned TICK_DIV   = 4
) (
    input  logic               clock,
    input  logic               reset,
    input  logic [SEL_W-1:0]   param_sel,
    input  logic [VALUE_W-1:0] param_value,
    input  logic               reprogram,
    input  logic [SEL_W-1:0]   interval,
    input  logic               start_timer,
    input  logic               cancel,
    output logic [VALUE_W-1:0] value,
    output logic [VALUE_W-1:0] remaining,
    output logic               busy,
    output logic               expired,
    output logic               prog_ack,
    output logic               prog_error
);

    localparam int unsigned PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

    typedef enum logic [1:0] {IDLE, COUNT, DONE} state_t;

    logic [VALUE_W-1:0] regs [NUM_PARAMS];
    logic               sel_hit;
    logic               write_ok;

    state_t             state;
    state_t             state_next;
    logic [PRE_W-1:0]   prescaler;
    logic [PRE_W-1:0]   prescaler_next;
    logic [VALUE_W-1:0] remaining_next;

    // Readout mux; out-of-range selectors read as zero and never hit a register.
    always_comb begin : readout
        value   = '0;
        sel_hit = 1'b0;
        for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
            if (interval == SEL_W'(i)) begin
                value = regs[i];
            end
            if (param_sel == SEL_W'(i)) begin
                sel_hit = 1'b1;
            end
        end
    end

`ifdef PARAM_TIMER_ZERO_REJECT_EN
    assign write_ok = reprogram && sel_hit && (param_value != '0);
`else
    assign write_ok = reprogram && sel_hit;
`endif

    always_ff @(posedge clock or posedge reset) begin : param_regs
        if (reset) begin
            for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
                regs[i] <= DEFAULTS[i*VALUE_W +: VALUE_W];
            end
            prog_ack   <= 1'b0;
            prog_error <= 1'b0;
        end else begin
            for (int unsigned i = 0; i < NUM_PARAMS; i++) begin
                if (write_ok && (param_sel == SEL_W'(i))) begin
                    regs[i] <= param_value;
                end
            end
            prog_ack   <= write_ok;
            prog_error <= reprogram && !write_ok;
        end
    end

    // Next-state logic: cancel beats start, start beats normal counting in any state.
    always_comb begin : next_state
        state_next     = state;
        prescaler_next = prescaler;
        remaining_next = remaining;
        if (cancel) begin
            state_next     = IDLE;
            prescaler_next = '0;
            remaining_next = '0;
        end else if (start_timer) begin
            prescaler_next = '0;
            remaining_next = value;
            state_next     = (value != '0) ? COUNT : DONE;
        end else begin
            case (state)
                IDLE: begin
                    state_next = IDLE;
                end
                COUNT: begin
                    if (prescaler == PRE_LAST) begin
                        prescaler_next = '0;
                        if (remaining != '0) begin
                            remaining_next = remaining - VALUE_W'(1);
                        end
                        if (remaining <= VALUE_W'(1)) begin
                            state_next = DONE;
                        end
                    end else begin
                        prescaler_next = prescaler + PRE_W'(1);
                    end
                end
                DONE: begin
                    state_next = IDLE;
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock or posedge reset) begin : state_reg
        if (reset) begin
            state     <= IDLE;
            prescaler <= '0;
            remaining <= '0;
            busy      <= 1'b0;
            expired   <= 1'b0;
        end else begin
            state     <= state_next;
            prescaler <= prescaler_next;
            remaining <= remaining_next;
            busy      <= (state_next == COUNT);
            expired   <= (state_next == DONE);
        end
    end

endmodule
